// File: rtl/bank_wr_pkg.sv
// Shared types for the bank write demux: FSM states, bank count and the word record
// carried through the skid buffer and output register.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 6
`endif

package bank_wr_pkg;
    localparam int WR_DATA_W = `DATA_WIDTH;
    localparam int WR_BANK_W = `BANK_WIDTH;
    localparam int WR_ADDR_W = 4;
    localparam int BANK_NUM  = 2 ** WR_BANK_W;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} wr_state_e;

    typedef struct packed {
        logic [WR_DATA_W-1:0] data;
        logic [WR_BANK_W-1:0] bank;
        logic [WR_ADDR_W-1:0] addr;
    } wr_word_t;
endpackage

// File: rtl/bank_wr_skid.sv
// 2-entry skid buffer; when empty and the consumer is ready the input word
// passes straight through so an accepted word reaches the output register next cycle.
module bank_wr_skid
    import bank_wr_pkg::*;
#(
    parameter int W = $bits(wr_word_t)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_word,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_word
);
    wr_word_t   r_mem [2];
    logic       r_wp;
    logic       r_rp;
    logic [1:0] r_cnt;
    logic       w_bypass;
    logic       w_push;
    logic       w_pop;

    // ready comes from the fill level only, never from the consumer side
    assign o_ready  = (r_cnt != 2'd2);
    assign o_valid  = (r_cnt != 2'd0) || i_valid;
    assign o_word   = (r_cnt != 2'd0) ? r_mem[r_rp] : i_word;
    assign w_bypass = (r_cnt == 2'd0) && i_ready;
    assign w_push   = i_valid && o_ready && !w_bypass;
    assign w_pop    = (r_cnt != 2'd0) && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_word;
                r_wp        <= !r_wp;
            end
            if (w_pop)
                r_rp <= !r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/bank_write_demux.sv
// Framed write demux: skid-buffered (data, bank, addr) stream to a one-hot bank write port.
// Define WR_STALL_CNT_EN to build the saturating input-stall counter on o_stall_cnt.
module bank_write_demux
    import bank_wr_pkg::*;
#(
    parameter int DATA_W    = WR_DATA_W,
    parameter int BANK_W    = WR_BANK_W,
    parameter int ADDR_W    = WR_ADDR_W,
    parameter int FRAME_LEN = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [DATA_W-1:0]   i_in_data,
    input  logic [BANK_W-1:0]   i_in_bank,
    input  logic [ADDR_W-1:0]   i_in_addr,
    input  logic                i_bank_ready,
    output logic [BANK_NUM-1:0] o_wen,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [ADDR_W-1:0]   o_waddr,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_stall_cnt
);
    localparam int               CNT_W = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

    wr_state_e        r_state;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    wr_word_t         r_out;
    logic             r_out_vld;

    logic     w_run;
    logic     w_skid_in_vld;
    logic     w_skid_ready;
    logic     w_skid_vld;
    logic     w_acc;
    logic     w_wr;
    logic     w_load;
    wr_word_t w_in_word;
    wr_word_t w_skid_word;

    assign w_run         = (r_state == RUN);
    assign w_in_word     = '{data: i_in_data, bank: i_in_bank, addr: i_in_addr};
    assign w_skid_in_vld = i_in_valid && w_run;

    bank_wr_skid u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (w_skid_in_vld),
        .o_ready (w_skid_ready),
        .i_word  (w_in_word),
        .o_valid (w_skid_vld),
        .i_ready (w_load),
        .o_word  (w_skid_word)
    );

    assign o_in_ready = w_run && w_skid_ready;
    assign w_acc      = i_in_valid && o_in_ready;
    assign w_wr       = r_out_vld && i_bank_ready;
    assign w_load     = !r_out_vld || w_wr;

    // output register holds its word across bank_ready stalls
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (w_load) begin
            r_out_vld <= w_skid_vld;
            if (w_skid_vld)
                r_out <= w_skid_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_in_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state  <= RUN;
                    r_busy   <= 1'b1;
                    r_in_cnt <= '0;
                    r_wr_cnt <= '0;
                end
                RUN: begin
                    if (w_acc) begin
                        r_in_cnt <= r_in_cnt + CNT_W'(1);
                        if (r_in_cnt == LAST)
                            r_state <= FLUSH;
                    end
                    if (w_wr)
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                end
                FLUSH: if (w_wr) begin
                    r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    if (r_wr_cnt == LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wen   = r_out_vld ? ({{(BANK_NUM-1){1'b0}}, 1'b1} << r_out.bank) : '0;
    assign o_wdata = r_out.data;
    assign o_waddr = r_out.addr;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

`ifdef WR_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_stall_cnt <= '0;
        else if (r_state == IDLE && i_start)
            r_stall_cnt <= '0;
        else if (r_busy && i_in_valid && !o_in_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 16'd0;
`endif
endmodule
